// File: rtl/ff_wnd_set.sv
// Sliding bitmap window over an absolute index space.
// Supports set/clear by absolute index, window advance, and base reload.
module ff_wnd_set #(
    parameter int WND_SIZE    = 128,
    parameter int IND_WIDTH   = 10,
    parameter int SHIFT_WIDTH = $clog2(WND_SIZE) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_val_in,
    input  logic [IND_WIDTH-1:0]   load_base_in,
    input  logic                   set_val_in,
    input  logic [IND_WIDTH-1:0]   set_ind_in,
    input  logic                   clr_val_in,
    input  logic [IND_WIDTH-1:0]   clr_ind_in,
    input  logic                   shift_val_in,
    input  logic [SHIFT_WIDTH-1:0] shift_cnt_in,
    output logic [WND_SIZE-1:0]    wnd_out,
    output logic [IND_WIDTH-1:0]   base_out,
    output logic                   set_ack_out,
    output logic                   set_oow_out,
    output logic [15:0]            oow_cnt_out
);

    localparam logic [IND_WIDTH-1:0]   WND_I = IND_WIDTH'(WND_SIZE);
    localparam logic [SHIFT_WIDTH-1:0] WND_S = SHIFT_WIDTH'(WND_SIZE);

    logic [IND_WIDTH-1:0]   set_off;
    logic [IND_WIDTH-1:0]   clr_off;
    logic                   set_hit;
    logic                   clr_hit;
    logic                   set_miss;
    logic                   clr_miss;
    logic [WND_SIZE-1:0]    set_dec;
    logic [WND_SIZE-1:0]    clr_dec;
    logic [WND_SIZE-1:0]    wnd_mod;
    logic [WND_SIZE-1:0]    wnd_nxt;
    logic [SHIFT_WIDTH-1:0] shamt;
    logic [IND_WIDTH-1:0]   base_nxt;
    logic [1:0]             inc;
    logic [16:0]            cnt_sum;
    logic [15:0]            cnt_nxt;

    // Offsets wrap modulo 2^IND_WIDTH so windows straddling zero decode.
    always_comb begin
        set_off  = set_ind_in - base_out;
        clr_off  = clr_ind_in - base_out;
        set_hit  = set_val_in && (set_off < WND_I);
        clr_hit  = clr_val_in && (clr_off < WND_I);
        set_miss = set_val_in && !(set_off < WND_I);
        clr_miss = clr_val_in && !(clr_off < WND_I);
    end

    always_comb begin
        set_dec = '0;
        clr_dec = '0;
        for (int k = 0; k < WND_SIZE; k++) begin
            set_dec[k] = set_hit && (set_off == IND_WIDTH'(k));
            clr_dec[k] = clr_hit && (clr_off == IND_WIDTH'(k));
        end
    end

    // Clear before set so set wins; the shift sees the merged bitmap.
    always_comb begin
        wnd_mod  = (wnd_out & ~clr_dec) | set_dec;
        wnd_nxt  = wnd_mod;
        base_nxt = base_out;
        shamt    = (shift_cnt_in > WND_S) ? WND_S : shift_cnt_in;
        if (shift_val_in) begin
            wnd_nxt  = (shamt == WND_S) ? '0 : (wnd_mod >> shamt);
            base_nxt = base_out + IND_WIDTH'(shift_cnt_in);
        end
    end

    always_comb begin
        inc     = {1'b0, set_miss} + {1'b0, clr_miss};
        cnt_sum = {1'b0, oow_cnt_out} + 17'(inc);
        cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wnd_out     <= '0;
            base_out    <= '0;
            set_ack_out <= 1'b0;
            set_oow_out <= 1'b0;
            oow_cnt_out <= '0;
        end else if (load_val_in) begin
            wnd_out     <= '0;
            base_out    <= load_base_in;
            set_ack_out <= 1'b0;
            set_oow_out <= 1'b0;
        end else begin
            wnd_out     <= wnd_nxt;
            base_out    <= base_nxt;
            set_ack_out <= set_hit;
            set_oow_out <= set_miss;
            oow_cnt_out <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ff_wnd_set.sv
// Directed bench for ff_wnd_set with a reference model feeding a
// queue of expected register states, compared after each edge.
module tb_ff_wnd_set;

    localparam int W  = 8;
    localparam int IW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_val;
    logic [IW-1:0] load_base;
    logic          set_val;
    logic [IW-1:0] set_ind;
    logic          clr_val;
    logic [IW-1:0] clr_ind;
    logic          shift_val;
    logic [SW-1:0] shift_cnt;
    logic [W-1:0]  wnd;
    logic [IW-1:0] base;
    logic          ack;
    logic          oow;
    logic [15:0]   cnt;

    typedef struct {
        logic [W-1:0]  wnd;
        logic [IW-1:0] base;
        logic          ack;
        logic          oow;
        logic [15:0]   cnt;
    } exp_t;

    exp_t q[$];

    logic [W-1:0]  m_wnd;
    logic [IW-1:0] m_base;
    logic [15:0]   m_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ff_wnd_set #(.WND_SIZE(W), .IND_WIDTH(IW), .SHIFT_WIDTH(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_val_in  (load_val),
        .load_base_in (load_base),
        .set_val_in   (set_val),
        .set_ind_in   (set_ind),
        .clr_val_in   (clr_val),
        .clr_ind_in   (clr_ind),
        .shift_val_in (shift_val),
        .shift_cnt_in (shift_cnt),
        .wnd_out      (wnd),
        .base_out     (base),
        .set_ack_out  (ack),
        .set_oow_out  (oow),
        .oow_cnt_out  (cnt)
    );

    task automatic step(input logic r, input logic lv, input int lb,
                        input logic sv, input int si,
                        input logic cv, input int ci,
                        input logic hv, input int sc,
                        input bit chk, input string tag);
        exp_t e;
        logic [IW-1:0] so, co;
        logic sin, cin;
        int s;
        exp_t got;
        rst = r; load_val = lv; load_base = IW'(lb);
        set_val = sv; set_ind = IW'(si);
        clr_val = cv; clr_ind = IW'(ci);
        shift_val = hv; shift_cnt = SW'(sc);
        e.ack = 1'b0;
        e.oow = 1'b0;
        if (r) begin
            m_wnd = '0; m_base = '0; m_cnt = '0;
        end else if (lv) begin
            m_wnd = '0; m_base = IW'(lb);
        end else begin
            so  = IW'(si) - m_base;
            co  = IW'(ci) - m_base;
            sin = (int'(so) < W);
            cin = (int'(co) < W);
            if (cv && cin) m_wnd[co[2:0]] = 1'b0;
            if (sv && sin) m_wnd[so[2:0]] = 1'b1;
            e.ack = sv && sin;
            e.oow = sv && !sin;
            if (sv && !sin) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (cv && !cin) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (hv) begin
                s = (sc > W) ? W : sc;
                for (int i = 0; i < W; i++)
                    m_wnd[i] = (i + s < W) ? m_wnd[i + s] : 1'b0;
                m_base = m_base + IW'(sc);
            end
        end
        e.wnd  = m_wnd;
        e.base = m_base;
        e.cnt  = m_cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        if (chk) begin
            checks += 5;
            assert (wnd === got.wnd) else begin
                fails++;
                $error("FAIL %s wnd got %h want %h", tag, wnd, got.wnd);
            end
            assert (base === got.base) else begin
                fails++;
                $error("FAIL %s base got %0d want %0d", tag, base, got.base);
            end
            assert (ack === got.ack) else begin
                fails++;
                $error("FAIL %s ack got %b want %b", tag, ack, got.ack);
            end
            assert (oow === got.oow) else begin
                fails++;
                $error("FAIL %s oow got %b want %b", tag, oow, got.oow);
            end
            assert (cnt === got.cnt) else begin
                fails++;
                $error("FAIL %s cnt got %h want %h", tag, cnt, got.cnt);
            end
        end
    endtask

    task automatic spot(input string tag, input logic [15:0] act,
                        input logic [15:0] req);
        checks++;
        assert (act === req) else begin
            fails++;
            $error("FAIL %s got %h want %h", tag, act, req);
        end
    endtask

    initial begin
        m_wnd = '0; m_base = '0; m_cnt = '0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst0");
        step(1, 0, 0, 1, 2, 0, 0, 1, 3, 1, "rst_req");
        step(0, 0, 0, 1, 3, 0, 0, 0, 0, 1, "set3");
        step(0, 0, 0, 1, 5, 0, 0, 0, 0, 1, "set5");
        spot("wnd_28", 16'(wnd), 16'h0028);
        step(0, 0, 0, 1, 7, 0, 0, 1, 3, 1, "sh3_set7");
        spot("wnd_15", 16'(wnd), 16'h0015);
        step(0, 1, 250, 1, 1, 1, 0, 1, 2, 1, "load250");
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, "set1_wrap");
        spot("wnd_80", 16'(wnd), 16'h0080);
        step(0, 0, 0, 1, 2, 0, 0, 0, 0, 1, "set2_oow");
        spot("cnt_1", cnt, 16'h0001);
        step(0, 0, 0, 1, 2, 1, 3, 0, 0, 1, "both_oow");
        spot("cnt_3", cnt, 16'h0003);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "load0");
        step(0, 0, 0, 1, 4, 1, 4, 0, 0, 1, "set_clr4");
        step(0, 0, 0, 0, 0, 1, 4, 0, 0, 1, "clr4");
        for (int i = 0; i < W; i++)
            step(0, 0, 0, 1, i, 0, 0, 0, 0, 1, "fill");
        spot("wnd_ff", 16'(wnd), 16'h00FF);
        step(0, 0, 0, 0, 0, 0, 0, 1, 8, 1, "sh8");
        spot("base_8", 16'(base), 16'd8);
        step(0, 0, 0, 0, 0, 0, 0, 1, 12, 1, "sh12");
        spot("base_20", 16'(base), 16'd20);
        step(0, 0, 0, 1, 26, 0, 0, 0, 0, 1, "set26");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "sh0");
        step(0, 0, 0, 1, 22, 0, 0, 1, 15, 1, "sh15");
        step(0, 0, 0, 1, 36, 0, 0, 1, 3, 1, "set_shout");
        step(0, 0, 0, 1, 0, 0, 0, 1, 9, 1, "sh9_oow");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "load_sat");
        for (int i = 0; i < 32768; i++)
            step(0, 0, 0, 1, 100, 1, 200, 0, 0, 0, "bulk");
        step(0, 0, 0, 1, 100, 1, 200, 0, 0, 1, "sat");
        spot("cnt_sat", cnt, 16'hFFFF);
        step(0, 0, 0, 1, 100, 0, 0, 0, 0, 1, "sat_oow");
        step(1, 0, 0, 1, 100, 0, 0, 0, 0, 1, "rst_mid");
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
